// File: rtl/inv_25519.sv
// -----------------------------------------------------------------------------
// inv_25519 : modular inverter over GF(2^255-19).
//
// Computes res = a^(P-2) mod P (Fermat inversion) by sequencing an external
// field multiplier through its start/done handshake, scanning the exponent
// left to right (square, then multiply by the base where the exponent bit is 1).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      begin an inversion; only sampled while idle
//   a          operand, canonical (0 <= a < P)
//   res        inverse of a mod P, valid when done pulses
//   done       one-cycle completion pulse
//   busy       operation in progress
//   zero       operand was 0, valid with done
//   error      watchdog abort, valid with done
//   mul_start  one-cycle request pulse to the multiplier
//   mul_a      multiplier operand A, stable from mul_start until mul_done
//   mul_b      multiplier operand B, stable likewise
//   mul_res    multiplier result, canonical mod P
//   mul_done   multiplier completion pulse
//
// WAIT_LIMIT bounds the cycles spent waiting for mul_done; 0 disables the
// watchdog.
// -----------------------------------------------------------------------------
module inv_25519 #(
    parameter int WAIT_LIMIT = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] a,
    output logic [254:0] res,
    output logic         done,
    output logic         busy,
    output logic         zero,
    output logic         error,
    output logic         mul_start,
    output logic [254:0] mul_a,
    output logic [254:0] mul_b,
    input  logic [254:0] mul_res,
    input  logic         mul_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR_REQ,
        SQR_WAIT,
        MUL_REQ,
        MUL_WAIT,
        FIN
    } state_t;

    state_t       state_q;
    logic [254:0] base_q;
    // mul_a_q doubles as the running accumulator: every request issues the
    // accumulator on operand A, so no separate copy is kept.
    logic [254:0] mul_a_q;
    logic [254:0] mul_b_q;
    logic [254:0] res_q;
    logic [7:0]   idx_q;
    logic [31:0]  wd_q;
    logic         done_q;
    logic         busy_q;
    logic         zero_q;
    logic         error_q;
    logic         mul_start_q;

    logic         ebit;
    logic         wd_expired;

    // Exponent P-2: bits 254..0 all set except bits 4 and 2.
    function automatic logic exp_bit(input logic [7:0] i);
        return !((i == 8'd4) || (i == 8'd2));
    endfunction

    assign ebit       = exp_bit(idx_q);
    assign wd_expired = (WAIT_LIMIT > 0) && (wd_q == 32'(WAIT_LIMIT));

    assign res       = res_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign zero      = zero_q;
    assign error     = error_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

    // Outputs are registered on the transition into each state, so a request
    // pulse and its operands appear in the REQ cycle itself, and res/done
    // appear together in the FIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_q       <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            zero_q      <= 1'b0;
            error_q     <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= a;
                        idx_q   <= 8'd253;
                        zero_q  <= 1'b0;
                        error_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (base_q == '0) begin
                        res_q   <= '0;
                        zero_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        // Top exponent bit is 1, so the accumulator starts at base.
                        mul_a_q     <= base_q;
                        mul_b_q     <= base_q;
                        mul_start_q <= 1'b1;
                        state_q     <= SQR_REQ;
                    end
                end
                SQR_REQ: begin
                    wd_q    <= '0;
                    state_q <= SQR_WAIT;
                end
                SQR_WAIT: begin
                    if (mul_done) begin
                        if (ebit) begin
                            mul_a_q     <= mul_res;
                            mul_b_q     <= base_q;
                            mul_start_q <= 1'b1;
                            state_q     <= MUL_REQ;
                        end else if (idx_q == 8'd0) begin
                            res_q   <= mul_res;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            idx_q       <= idx_q - 8'd1;
                            mul_a_q     <= mul_res;
                            mul_b_q     <= mul_res;
                            mul_start_q <= 1'b1;
                            state_q     <= SQR_REQ;
                        end
                    end else if (wd_expired) begin
                        error_q <= 1'b1;
                        res_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
                end
                MUL_REQ: begin
                    wd_q    <= '0;
                    state_q <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        if (idx_q == 8'd0) begin
                            res_q   <= mul_res;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            idx_q       <= idx_q - 8'd1;
                            mul_a_q     <= mul_res;
                            mul_b_q     <= mul_res;
                            mul_start_q <= 1'b1;
                            state_q     <= SQR_REQ;
                        end
                    end else if (wd_expired) begin
                        error_q <= 1'b1;
                        res_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
                end
                FIN: begin
                    // start seen here is deliberately dropped.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_25519.sv
// -----------------------------------------------------------------------------
// Testbench for inv_25519. Two instances share clock and reset: the main one
// (default watchdog) is served by a behavioural multiplier with configurable
// latency; the second (WAIT_LIMIT=16) never receives mul_done.
// Done-cycle offsets count the cycle in which start is sampled as cycle 0.
// -----------------------------------------------------------------------------
module tb_inv_25519;

    localparam logic [255:0] P_W    = (256'd1 << 255) - 256'd19;
    localparam logic [254:0] P      = P_W[254:0];
    localparam logic [255:0] HALF_W = (256'd1 << 254) - 256'd9;
    localparam logic [254:0] HALF   = HALF_W[254:0];

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [254:0] a;
    logic [254:0] res;
    logic         done, busy, zero, error, mul_start, mul_done;
    logic [254:0] mul_a, mul_b, mul_res;

    logic         start_wd;
    logic [254:0] a_wd;
    logic [254:0] res_wd;
    logic         done_wd, busy_wd, zero_wd, error_wd, mul_start_wd, mul_done_wd;
    logic [254:0] mul_a_wd, mul_b_wd, mul_res_wd;

    int n_pass  = 0;
    int n_total = 0;

    // multiplier model state
    int           cnt = 0;
    int           lat;
    int           lat_fixed = 1;
    int           lat_sum = 0;
    int           op_cnt = 0;
    int           viol = 0;
    logic [254:0] cap_a, cap_b, cap_r;

    always #5 clk = ~clk;

    inv_25519 dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .res(res), .done(done),
        .busy(busy), .zero(zero), .error(error), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .mul_done(mul_done)
    );

    inv_25519 #(.WAIT_LIMIT(16)) dut_wd (
        .clk(clk), .rst(rst), .start(start_wd), .a(a_wd), .res(res_wd), .done(done_wd),
        .busy(busy_wd), .zero(zero_wd), .error(error_wd), .mul_start(mul_start_wd),
        .mul_a(mul_a_wd), .mul_b(mul_b_wd), .mul_res(mul_res_wd), .mul_done(mul_done_wd)
    );

    function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
        logic [509:0] p;
        p = 510'(x) * 510'(y);
        return 255'(p % 510'(P));
    endfunction

    // Right-to-left binary exponentiation x^(P-2) mod P.
    function automatic logic [254:0] inv_ref(input logic [254:0] x);
        logic [254:0] r, b, e;
        r = 255'd1;
        b = x;
        e = P - 255'd2;
        while (e != '0) begin
            if (e[0]) r = mulmod(r, b);
            b = mulmod(b, b);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic logic [254:0] rand255();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom;
        return t[254:0];
    endfunction

    // Behavioural multiplier: result = a*b mod P, mul_done Lm cycles after the
    // mul_start cycle; garbage on mul_res otherwise. Flags protocol violations.
    initial begin
        mul_done = 1'b0;
        mul_res  = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            mul_res  = rand255();
            if (rst) begin
                cnt = 0;
            end else if (cnt > 0) begin
                if (mul_start || mul_a !== cap_a || mul_b !== cap_b) viol++;
                cnt--;
                if (cnt == 0) begin
                    mul_done = 1'b1;
                    mul_res  = cap_r;
                end
            end else if (mul_start) begin
                cap_a = mul_a;
                cap_b = mul_b;
                cap_r = mulmod(cap_a, cap_b);
                lat   = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 80));
                lat_sum += lat + 1;
                op_cnt++;
                cnt = lat;
            end
        end
    end

    task automatic run_inv(input logic [254:0] av, output logic [254:0] r, output bit z,
                           output bit e, output int cyc, output int ops,
                           output int busy_bad, output bit to);
        int ops0;
        @(negedge clk);
        a = av;
        start = 1'b1;
        ops0 = op_cnt;
        lat_sum = 0;
        r = '0; z = 1'b0; e = 1'b0; cyc = 0; busy_bad = 0; to = 1'b1;
        for (int k = 1; k <= 50000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                cyc = k; r = res; z = zero; e = error; to = 1'b0;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
        end
        ops = op_cnt - ops0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0;
        start_wd = 1'b0; a_wd = '0; mul_done_wd = 1'b0; mul_res_wd = '0;
        repeat (2) @(negedge clk);
        n_total++; if (res !== '0) $display("FAIL rst_res: got %h want 0", res); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (zero !== 1'b0) $display("FAIL rst_zero: got %b want 0", zero); else n_pass++;
        n_total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else n_pass++;
        n_total++; if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %b want 0", mul_start); else n_pass++;
        n_total++; if (mul_a !== '0) $display("FAIL rst_mul_a: got %h want 0", mul_a); else n_pass++;
        n_total++; if (mul_b !== '0) $display("FAIL rst_mul_b: got %h want 0", mul_b); else n_pass++;
        n_total++; if (busy_wd !== 1'b0) $display("FAIL rst_wd_busy: got %b want 0", busy_wd); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_one();
        logic [254:0] r; bit z, e, to; int cyc, ops, bb;
        lat_fixed = 67;
        run_inv(255'd1, r, z, e, cyc, ops, bb, to);
        n_total++; if (to) $display("FAIL one_timeout: got no done want done"); else n_pass++;
        n_total++; if (r !== 255'd1) $display("FAIL one_res: got %h want 1", r); else n_pass++;
        n_total++; if (ops != 506) $display("FAIL one_ops: got %0d want 506", ops); else n_pass++;
        n_total++; if (cyc != 2 + 506 * 68) $display("FAIL one_latency: got %0d want %0d", cyc, 2 + 506 * 68); else n_pass++;
        n_total++; if (z !== 1'b0) $display("FAIL one_zero: got %b want 0", z); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL one_error: got %b want 0", e); else n_pass++;
        n_total++; if (bb != 0) $display("FAIL one_busy: got %0d bad cycles want 0", bb); else n_pass++;
        n_total++; if (viol != 0) $display("FAIL one_protocol: got %0d violations want 0", viol); else n_pass++;
    endtask

    task automatic test_two_random_latency();
        logic [254:0] r; bit z, e, to; int cyc, ops, bb;
        lat_fixed = 0;
        run_inv(255'd2, r, z, e, cyc, ops, bb, to);
        n_total++; if (r !== HALF) $display("FAIL two_res: got %h want %h", r, HALF); else n_pass++;
        n_total++; if (mulmod(255'd2, r) !== 255'd1) $display("FAIL two_product: got %h want 1", mulmod(255'd2, r)); else n_pass++;
        n_total++; if (ops != 506) $display("FAIL two_ops: got %0d want 506", ops); else n_pass++;
        n_total++; if (cyc != 2 + lat_sum) $display("FAIL two_latency: got %0d want %0d", cyc, 2 + lat_sum); else n_pass++;
        n_total++; if (bb != 0) $display("FAIL two_busy: got %0d bad cycles want 0", bb); else n_pass++;
        lat_fixed = 1;
    endtask

    task automatic test_known_values();
        logic [254:0] r, v, ref_v; bit z, e, to; int cyc, ops, bb;
        lat_fixed = 1;
        run_inv(P - 255'd1, r, z, e, cyc, ops, bb, to);
        n_total++; if (r !== P - 255'd1) $display("FAIL pm1_res: got %h want %h", r, P - 255'd1); else n_pass++;
        n_total++; if (cyc != 2 + 506 * 2) $display("FAIL pm1_latency: got %0d want %0d", cyc, 2 + 506 * 2); else n_pass++;
        v = 255'h1234_5678_9abc_def0_0fed_cba9_8765_4321_1357_9bdf_2468_ace0_dead_beef_cafe_f00d;
        ref_v = inv_ref(v);
        run_inv(v, r, z, e, cyc, ops, bb, to);
        n_total++; if (r !== ref_v) $display("FAIL k1234_res: got %h want %h", r, ref_v); else n_pass++;
        n_total++; if (mulmod(v, r) !== 255'd1) $display("FAIL k1234_product: got %h want 1", mulmod(v, r)); else n_pass++;
    endtask

    task automatic test_random_values();
        logic [254:0] r, v, ref_v; bit z, e, to; int cyc, ops, bb;
        lat_fixed = 1;
        for (int n = 0; n < 12; n++) begin
            v = rand255();
            if (v >= P) v = v - P;
            if (v == '0) v = 255'd3;
            ref_v = inv_ref(v);
            run_inv(v, r, z, e, cyc, ops, bb, to);
            n_total++; if (r !== ref_v) $display("FAIL rand%0d_res: a %h got %h want %h", n, v, r, ref_v); else n_pass++;
            n_total++; if (mulmod(v, r) !== 255'd1) $display("FAIL rand%0d_product: got %h want 1", n, mulmod(v, r)); else n_pass++;
        end
    endtask

    task automatic test_zero();
        logic [254:0] r; bit z, e, to; int cyc, ops, bb, ms_seen, busy_seen;
        run_inv(255'd0, r, z, e, cyc, ops, bb, to);
        n_total++; if (ops != 0) $display("FAIL zero_ops: got %0d want 0", ops); else n_pass++;
        n_total++; if (cyc != 2) $display("FAIL zero_latency: got %0d want 2", cyc); else n_pass++;
        n_total++; if (r !== '0) $display("FAIL zero_res: got %h want 0", r); else n_pass++;
        n_total++; if (z !== 1'b1) $display("FAIL zero_flag: got %b want 1", z); else n_pass++;
        n_total++; if (e !== 1'b0) $display("FAIL zero_error: got %b want 0", e); else n_pass++;
        // start raised during the done cycle must be dropped
        a = 255'd1;
        start = 1'b1;
        ms_seen = 0; busy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (mul_start) ms_seen++;
            if (busy) busy_seen++;
        end
        n_total++; if (busy_seen != 0 || ms_seen != 0) $display("FAIL fin_start_ignored: got busy %0d mul_start %0d want 0 0", busy_seen, ms_seen); else n_pass++;
        n_total++; if (zero !== 1'b1) $display("FAIL zero_hold: got %b want 1", zero); else n_pass++;
        run_inv(255'd1, r, z, e, cyc, ops, bb, to);
        n_total++; if (z !== 1'b0) $display("FAIL zero_clear: got %b want 0", z); else n_pass++;
        n_total++; if (r !== 255'd1) $display("FAIL zero_then_one_res: got %h want 1", r); else n_pass++;
    endtask

    task automatic test_watchdog();
        int first_ms, ms_cnt, dk, dk2, bad_idle;
        @(negedge clk);
        a_wd = 255'd5;
        start_wd = 1'b1;
        first_ms = -1; ms_cnt = 0; dk = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (mul_start_wd) begin
                ms_cnt++;
                if (first_ms < 0) first_ms = k;
            end
            if (done_wd) begin
                dk = k;
                break;
            end
            start_wd = (k % 3 == 0);
            a_wd = rand255();
        end
        start_wd = 1'b0;
        n_total++; if (dk < 0 || dk - first_ms < 17 || dk - first_ms > 18) $display("FAIL wd_latency: got %0d want 17..18", dk - first_ms); else n_pass++;
        n_total++; if (error_wd !== 1'b1) $display("FAIL wd_error: got %b want 1", error_wd); else n_pass++;
        n_total++; if (res_wd !== '0) $display("FAIL wd_res: got %h want 0", res_wd); else n_pass++;
        n_total++; if (zero_wd !== 1'b0) $display("FAIL wd_zero: got %b want 0", zero_wd); else n_pass++;
        n_total++; if (ms_cnt != 1) $display("FAIL wd_mul_starts: got %0d want 1", ms_cnt); else n_pass++;
        bad_idle = 0;
        repeat (3) begin
            @(negedge clk);
            if (error_wd !== 1'b1 || busy_wd !== 1'b0) bad_idle++;
        end
        n_total++; if (bad_idle != 0) $display("FAIL wd_error_hold: got %0d bad cycles want 0", bad_idle); else n_pass++;
        a_wd = '0;
        start_wd = 1'b1;
        dk2 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_wd = 1'b0;
            if (done_wd) begin
                dk2 = k;
                break;
            end
        end
        n_total++; if (dk2 != 2) $display("FAIL wd_zero_latency: got %0d want 2", dk2); else n_pass++;
        n_total++; if (zero_wd !== 1'b1 || error_wd !== 1'b0) $display("FAIL wd_flags_after_restart: got zero %b error %b want 1 0", zero_wd, error_wd); else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [254:0] r; bit z, e, to; int cyc, ops, bb, ops0, done_seen;
        lat_fixed = 1;
        @(negedge clk);
        a = 255'd7;
        start = 1'b1;
        ops0 = op_cnt;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (op_cnt - ops0 >= 200) break;
            @(negedge clk);
        end
        n_total++; if (op_cnt - ops0 < 200) $display("FAIL midop_reach: got %0d ops want 200", op_cnt - ops0); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (res !== '0) $display("FAIL midop_res: got %h want 0", res); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midop_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (mul_start !== 1'b0) $display("FAIL midop_mul_start: got %b want 0", mul_start); else n_pass++;
        n_total++; if (mul_a !== '0 || mul_b !== '0) $display("FAIL midop_operands: got %h %h want 0 0", mul_a, mul_b); else n_pass++;
        n_total++; if (done !== 1'b0 || zero !== 1'b0 || error !== 1'b0) $display("FAIL midop_flags: got done %b zero %b error %b want 0 0 0", done, zero, error); else n_pass++;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        n_total++; if (done_seen != 0) $display("FAIL midop_no_done: got %0d active cycles want 0", done_seen); else n_pass++;
        run_inv(255'd2, r, z, e, cyc, ops, bb, to);
        n_total++; if (r !== HALF) $display("FAIL midop_restart_res: got %h want %h", r, HALF); else n_pass++;
        n_total++; if (ops != 506) $display("FAIL midop_restart_ops: got %0d want 506", ops); else n_pass++;
        n_total++; if (viol != 0) $display("FAIL protocol_total: got %0d violations want 0", viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_one();
        test_two_random_latency();
        test_known_values();
        test_random_values();
        test_zero();
        test_watchdog();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
